// File: rtl/mix_layer_param.sv
// ---------------------------------------------------------------------------
// mix_layer_param
//   Trainable DIM x DIM linear layer in signed fixed point (FRAC fraction
//   bits). It holds the weights W, the gradient accumulator dW, the last
//   forward input x_fwd and the input x_bwd that the backward pass uses.
//   Three independent sequencers each do one multiply-accumulate per cycle:
//     forward  : y  = W   * x    -> q_forward
//     backward : dx = W^T * dy   -> q_backward, and dW += outer(dy, x_bwd)
//     update   : W  = W - dW * 2^-LR_SHIFT  (SGD step)
//   zero_grad clears all of dW in a single cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   run_forward       forward request (level), d_forward = x (packed words)
//   valid_forward     q_forward holds y; stays high until run_forward drops
//   load_backward     copy x_fwd into x_bwd (ignored during backward CALC)
//   run_backward      backward request (level), d_backward = dy
//   valid_backward    q_backward holds dx; stays high until run_backward drops
//   zero_grad         clear dW request (level); valid_zero_grad acknowledges
//   update            SGD step request (level); valid_update acknowledges
//   Vector element k lives at bits [k*N_LEN +: N_LEN].
// ---------------------------------------------------------------------------
module mix_layer_param #(
    parameter int DIM      = 4,
    parameter int N_LEN    = 16,
    parameter int FRAC     = 8,
    parameter int LR_SHIFT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run_forward,
    input  logic [DIM*N_LEN-1:0]   d_forward,
    output logic                   valid_forward,
    output logic [DIM*N_LEN-1:0]   q_forward,
    input  logic                   load_backward,
    input  logic                   run_backward,
    input  logic [DIM*N_LEN-1:0]   d_backward,
    output logic                   valid_backward,
    output logic [DIM*N_LEN-1:0]   q_backward,
    input  logic                   zero_grad,
    output logic                   valid_zero_grad,
    input  logic                   update,
    output logic                   valid_update
);

    // state  | meaning
    // IDLE   | waiting for a request
    // CALC   | one MAC / element step per cycle, DIM*DIM cycles
    // DONE   | first edge publishes result + valid, then hold until request drops
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int ACC_W = 2*N_LEN + $clog2(DIM);
    localparam int SAT_W = ACC_W + 1;
    localparam int IW    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIM-1);

    typedef logic signed [N_LEN-1:0] word_t;

    word_t w_mem  [DIM][DIM];
    word_t dw_mem [DIM][DIM];
    word_t x_fwd  [DIM];
    word_t x_bwd  [DIM];
    word_t dy_buf [DIM];
    word_t fwd_y  [DIM];
    word_t bwd_y  [DIM];

    logic [1:0] fwd_state, bwd_state, upd_state;

    // Clamp a wide signed value into the signed N_LEN range.
    function automatic word_t sat_word(input logic signed [SAT_W-1:0] v);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (SAT_W'(1) <<< (N_LEN-1)) - SAT_W'(1);
        min_v = -(SAT_W'(1) <<< (N_LEN-1));
        if (v > max_v)
            return max_v[N_LEN-1:0];
        else if (v < min_v)
            return min_v[N_LEN-1:0];
        else
            return v[N_LEN-1:0];
    endfunction

    // Forward and backward may not start while an update is touching W, and
    // an update only starts when neither pass is busy nor being requested
    // in the same cycle (the passes win the tie).
    logic fwd_start, bwd_start, upd_start, zg_start;

    assign fwd_start = (fwd_state == ST_IDLE) && run_forward  && (upd_state == ST_IDLE);
    assign bwd_start = (bwd_state == ST_IDLE) && run_backward && (upd_state == ST_IDLE);
    assign upd_start = (upd_state == ST_IDLE) && update &&
                       (fwd_state == ST_IDLE) && (bwd_state == ST_IDLE) &&
                       !run_forward && !run_backward;
    assign zg_start  = zero_grad && !valid_zero_grad && (bwd_state != ST_CALC);

    // ------------------------------------------------------------------
    // Forward: row-major walk, fwd_i = output row, fwd_j = input column.
    // ------------------------------------------------------------------
    logic [IW-1:0]             fwd_i, fwd_j;
    logic signed [ACC_W-1:0]   fwd_acc;
    logic signed [2*N_LEN-1:0] fwd_prod;
    logic signed [ACC_W-1:0]   fwd_sum;

    always_comb begin
        fwd_prod = (2*N_LEN)'(w_mem[fwd_i][fwd_j]) * (2*N_LEN)'(x_fwd[fwd_j]);
        fwd_sum  = fwd_acc + ACC_W'(fwd_prod);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_state     <= ST_IDLE;
            fwd_i         <= '0;
            fwd_j         <= '0;
            fwd_acc       <= '0;
            valid_forward <= 1'b0;
            q_forward     <= '0;
            for (int k = 0; k < DIM; k++) begin
                x_fwd[k] <= '0;
                fwd_y[k] <= '0;
            end
        end else begin
            case (fwd_state)
                ST_IDLE: begin
                    if (fwd_start) begin
                        for (int k = 0; k < DIM; k++)
                            x_fwd[k] <= d_forward[k*N_LEN +: N_LEN];
                        fwd_i     <= '0;
                        fwd_j     <= '0;
                        fwd_acc   <= '0;
                        fwd_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (fwd_j == IDX_LAST) begin
                        fwd_y[fwd_i] <= sat_word(SAT_W'(fwd_sum >>> FRAC));
                        fwd_acc      <= '0;
                        fwd_j        <= '0;
                        if (fwd_i == IDX_LAST)
                            fwd_state <= ST_DONE;
                        else
                            fwd_i <= fwd_i + IW'(1);
                    end else begin
                        fwd_acc <= fwd_sum;
                        fwd_j   <= fwd_j + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (!valid_forward) begin
                        valid_forward <= 1'b1;
                        for (int k = 0; k < DIM; k++)
                            q_forward[k*N_LEN +: N_LEN] <= fwd_y[k];
                    end else if (!run_forward) begin
                        valid_forward <= 1'b0;
                        fwd_state     <= ST_IDLE;
                    end
                end
                default: fwd_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Backward: column-major walk (bwd_j outer, bwd_i inner) so each dx[j]
    // finishes on consecutive cycles. The same visit also accumulates the
    // gradient for element (bwd_i, bwd_j); every element is visited once.
    // ------------------------------------------------------------------
    logic [IW-1:0]             bwd_i, bwd_j;
    logic signed [ACC_W-1:0]   bwd_acc;
    logic signed [2*N_LEN-1:0] bwd_prod;
    logic signed [ACC_W-1:0]   bwd_sum;
    logic signed [2*N_LEN-1:0] grad_prod;
    logic signed [SAT_W-1:0]   grad_sum;

    always_comb begin
        bwd_prod  = (2*N_LEN)'(w_mem[bwd_i][bwd_j]) * (2*N_LEN)'(dy_buf[bwd_i]);
        bwd_sum   = bwd_acc + ACC_W'(bwd_prod);
        grad_prod = (2*N_LEN)'(dy_buf[bwd_i]) * (2*N_LEN)'(x_bwd[bwd_j]);
        grad_sum  = SAT_W'(dw_mem[bwd_i][bwd_j]) + SAT_W'(grad_prod >>> FRAC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bwd_state       <= ST_IDLE;
            bwd_i           <= '0;
            bwd_j           <= '0;
            bwd_acc         <= '0;
            valid_backward  <= 1'b0;
            q_backward      <= '0;
            valid_zero_grad <= 1'b0;
            for (int r = 0; r < DIM; r++) begin
                x_bwd[r]  <= '0;
                dy_buf[r] <= '0;
                bwd_y[r]  <= '0;
                for (int c = 0; c < DIM; c++)
                    dw_mem[r][c] <= '0;
            end
        end else begin
            case (bwd_state)
                ST_IDLE: begin
                    if (bwd_start) begin
                        for (int k = 0; k < DIM; k++)
                            dy_buf[k] <= d_backward[k*N_LEN +: N_LEN];
                        bwd_i     <= '0;
                        bwd_j     <= '0;
                        bwd_acc   <= '0;
                        bwd_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    dw_mem[bwd_i][bwd_j] <= sat_word(grad_sum);
                    if (bwd_i == IDX_LAST) begin
                        bwd_y[bwd_j] <= sat_word(SAT_W'(bwd_sum >>> FRAC));
                        bwd_acc      <= '0;
                        bwd_i        <= '0;
                        if (bwd_j == IDX_LAST)
                            bwd_state <= ST_DONE;
                        else
                            bwd_j <= bwd_j + IW'(1);
                    end else begin
                        bwd_acc <= bwd_sum;
                        bwd_i   <= bwd_i + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (!valid_backward) begin
                        valid_backward <= 1'b1;
                        for (int k = 0; k < DIM; k++)
                            q_backward[k*N_LEN +: N_LEN] <= bwd_y[k];
                    end else if (!run_backward) begin
                        valid_backward <= 1'b0;
                        bwd_state      <= ST_IDLE;
                    end
                end
                default: bwd_state <= ST_IDLE;
            endcase

            // x_bwd must stay stable while the gradient walk reads it.
            if (load_backward && (bwd_state != ST_CALC)) begin
                for (int k = 0; k < DIM; k++)
                    x_bwd[k] <= x_fwd[k];
            end

            // zg_start excludes CALC, so this never collides with the
            // per-element gradient write above.
            if (zg_start) begin
                for (int r = 0; r < DIM; r++)
                    for (int c = 0; c < DIM; c++)
                        dw_mem[r][c] <= '0;
                valid_zero_grad <= 1'b1;
            end else if (valid_zero_grad && !zero_grad) begin
                valid_zero_grad <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Update: row-major, one weight per cycle. Sole writer of W.
    // ------------------------------------------------------------------
    logic [IW-1:0] upd_i, upd_j;
    word_t         w_next;

    always_comb begin
        w_next = sat_word(SAT_W'(w_mem[upd_i][upd_j]) -
                          SAT_W'(dw_mem[upd_i][upd_j] >>> LR_SHIFT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_state    <= ST_IDLE;
            upd_i        <= '0;
            upd_j        <= '0;
            valid_update <= 1'b0;
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) begin
                    if (r == c)
                        w_mem[r][c] <= word_t'(1 << FRAC);
                    else
                        w_mem[r][c] <= '0;
                end
        end else begin
            case (upd_state)
                ST_IDLE: begin
                    if (upd_start) begin
                        upd_i     <= '0;
                        upd_j     <= '0;
                        upd_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    w_mem[upd_i][upd_j] <= w_next;
                    if (upd_j == IDX_LAST) begin
                        upd_j <= '0;
                        if (upd_i == IDX_LAST)
                            upd_state <= ST_DONE;
                        else
                            upd_i <= upd_i + IW'(1);
                    end else begin
                        upd_j <= upd_j + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (!valid_update) begin
                        valid_update <= 1'b1;
                    end else if (!update) begin
                        valid_update <= 1'b0;
                        upd_state    <= ST_IDLE;
                    end
                end
                default: upd_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_layer_param.sv
// ---------------------------------------------------------------------------
// tb_mix_layer_param
//   Self-checking bench for mix_layer_param (DIM=4, N_LEN=16, FRAC=8,
//   LR_SHIFT=4). Directed vector tables and sequences, then a random mix of
//   operations checked against a plain-arithmetic model of the layer.
// ---------------------------------------------------------------------------
module tb_mix_layer_param;

    localparam int DIM      = 4;
    localparam int N_LEN    = 16;
    localparam int FRAC     = 8;
    localparam int LR_SHIFT = 4;
    localparam int ONE      = 1 << FRAC;
    localparam int LAT      = DIM*DIM + 1;
    localparam int TMO      = 200;
    localparam int MAXV     = (1 << (N_LEN-1)) - 1;
    localparam int MINV     = -(1 << (N_LEN-1));

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 run_forward, load_backward, run_backward, zero_grad, update;
    logic [DIM*N_LEN-1:0] d_forward, d_backward;
    logic [DIM*N_LEN-1:0] q_forward, q_backward;
    logic                 valid_forward, valid_backward, valid_zero_grad, valid_update;

    always #5 clk = ~clk;

    mix_layer_param #(
        .DIM(DIM), .N_LEN(N_LEN), .FRAC(FRAC), .LR_SHIFT(LR_SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run_forward(run_forward),
        .d_forward(d_forward),
        .valid_forward(valid_forward),
        .q_forward(q_forward),
        .load_backward(load_backward),
        .run_backward(run_backward),
        .d_backward(d_backward),
        .valid_backward(valid_backward),
        .q_backward(q_backward),
        .zero_grad(zero_grad),
        .valid_zero_grad(valid_zero_grad),
        .update(update),
        .valid_update(valid_update)
    );

    int checks = 0;
    int errors = 0;

    typedef int vec_t [DIM];
    typedef struct {
        int   phase;
        vec_t x;
        vec_t y;
    } fwd_rec_t;

    fwd_rec_t tbl [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DIM*N_LEN-1:0] pack(input vec_t v);
        logic [DIM*N_LEN-1:0] p;
        p = '0;
        for (int k = 0; k < DIM; k++)
            p[k*N_LEN +: N_LEN] = N_LEN'(v[k]);
        return p;
    endfunction

    task automatic unpack(input logic [DIM*N_LEN-1:0] p, output vec_t v);
        for (int k = 0; k < DIM; k++)
            v[k] = int'($signed(p[k*N_LEN +: N_LEN]));
    endtask

    task automatic check_vec(input string name, input vec_t act, input vec_t exp);
        for (int k = 0; k < DIM; k++)
            check($sformatf("%s[%0d]", name, k), act[k], exp[k]);
    endtask

    // ---------------- reference model ----------------
    int   w_m  [DIM][DIM];
    int   dw_m [DIM][DIM];
    vec_t xf_m, xb_m;

    function automatic int sat_m(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return int'(v);
    endfunction

    task automatic model_reset;
        for (int i = 0; i < DIM; i++) begin
            xf_m[i] = 0;
            xb_m[i] = 0;
            for (int j = 0; j < DIM; j++) begin
                w_m[i][j]  = (i == j) ? ONE : 0;
                dw_m[i][j] = 0;
            end
        end
    endtask

    task automatic model_forward(input vec_t x, output vec_t y);
        xf_m = x;
        for (int i = 0; i < DIM; i++) begin
            longint s = 0;
            for (int j = 0; j < DIM; j++)
                s += longint'(w_m[i][j]) * longint'(x[j]);
            y[i] = sat_m(s >>> FRAC);
        end
    endtask

    task automatic model_backward(input vec_t dy, output vec_t dx);
        for (int j = 0; j < DIM; j++) begin
            longint s = 0;
            for (int i = 0; i < DIM; i++)
                s += longint'(w_m[i][j]) * longint'(dy[i]);
            dx[j] = sat_m(s >>> FRAC);
        end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                dw_m[i][j] = sat_m(longint'(dw_m[i][j]) +
                                   ((longint'(dy[i]) * longint'(xb_m[j])) >>> FRAC));
    endtask

    task automatic model_update;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                w_m[i][j] = sat_m(longint'(w_m[i][j]) - longint'(dw_m[i][j] >>> LR_SHIFT));
    endtask

    // ---------------- DUT drivers ----------------
    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        run_forward = 1'b0; run_backward = 1'b0; load_backward = 1'b0;
        zero_grad = 1'b0; update = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_fwd(input vec_t x, output vec_t y, output int lat);
        @(negedge clk);
        d_forward   = pack(x);
        run_forward = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!valid_forward && lat < TMO);
        unpack(q_forward, y);
        @(negedge clk);
        run_forward = 1'b0;
        @(posedge clk); #1;
        check("fwd release", int'(valid_forward), 0);
    endtask

    task automatic run_bwd(input vec_t dy, output vec_t dx, output int lat);
        @(negedge clk);
        d_backward   = pack(dy);
        run_backward = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!valid_backward && lat < TMO);
        unpack(q_backward, dx);
        @(negedge clk);
        run_backward = 1'b0;
        @(posedge clk); #1;
        check("bwd release", int'(valid_backward), 0);
    endtask

    task automatic run_upd(output int lat);
        @(negedge clk);
        update = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!valid_update && lat < TMO);
        @(negedge clk);
        update = 1'b0;
        @(posedge clk); #1;
        check("upd release", int'(valid_update), 0);
    endtask

    task automatic run_zg;
        @(negedge clk);
        zero_grad = 1'b1;
        @(posedge clk); #1;
        check("zg rise", int'(valid_zero_grad), 1);
        @(negedge clk);
        zero_grad = 1'b0;
        @(posedge clk); #1;
        check("zg release", int'(valid_zero_grad), 0);
    endtask

    task automatic do_load;
        @(negedge clk);
        load_backward = 1'b1;
        @(negedge clk);
        load_backward = 1'b0;
    endtask

    function automatic int rnd_word();
        if ($urandom_range(0, 3) == 0)
            return int'($signed(16'($urandom)));
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t x, y, e, dx;
        int   lat;
        int   early;

        rst = 1'b1;
        run_forward = 1'b0; run_backward = 1'b0; load_backward = 1'b0;
        zero_grad = 1'b0; update = 1'b0;
        d_forward = '0; d_backward = '0;

        tbl[0].phase = 0; tbl[0].x = '{256, 512, -256, 128};   tbl[0].y = '{256, 512, -256, 128};
        tbl[1].phase = 0; tbl[1].x = '{32767, -32768, 1, -1};  tbl[1].y = '{32767, -32768, 1, -1};
        tbl[2].phase = 0; tbl[2].x = '{0, 0, 0, 0};            tbl[2].y = '{0, 0, 0, 0};
        tbl[3].phase = 0; tbl[3].x = '{-1000, 77, 4096, -5};   tbl[3].y = '{-1000, 77, 4096, -5};
        tbl[4].phase = 1; tbl[4].x = '{32767, 0, 0, 0};        tbl[4].y = '{32767, 0, 0, 0};
        tbl[5].phase = 1; tbl[5].x = '{100, -3, 9, 1};         tbl[5].y = '{200, -3, 9, 1};
        tbl[6].phase = 1; tbl[6].x = '{-20000, 5, 6, 7};       tbl[6].y = '{-32768, 5, 6, 7};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset valid_forward", int'(valid_forward), 0);
        check("reset valid_backward", int'(valid_backward), 0);
        check("reset valid_zero_grad", int'(valid_zero_grad), 0);
        check("reset valid_update", int'(valid_update), 0);
        check("reset q_forward", int'(q_forward != '0), 0);
        check("reset q_backward", int'(q_backward != '0), 0);

        // identity-weight table
        for (int t = 0; t < 7; t++) begin
            if (tbl[t].phase == 0) begin
                run_fwd(tbl[t].x, y, lat);
                check($sformatf("tbl%0d latency", t), lat, LAT);
                check_vec($sformatf("tbl%0d y", t), y, tbl[t].y);
            end
        end

        // raise W[0][0] to 512 through a backward pass and an update
        do_reset;
        run_fwd('{256, 0, 0, 0}, y, lat);
        do_load;
        run_bwd('{-4096, 0, 0, 0}, dx, lat);
        check("w512 bwd latency", lat, LAT);
        check_vec("w512 dx", dx, '{-4096, 0, 0, 0});
        run_upd(lat);
        check("w512 upd latency", lat, LAT);
        for (int t = 0; t < 7; t++) begin
            if (tbl[t].phase == 1) begin
                run_fwd(tbl[t].x, y, lat);
                check_vec($sformatf("tbl%0d y", t), y, tbl[t].y);
            end
        end

        // one SGD step with dW[0][0]=256 gives W[0][0]=240
        do_reset;
        run_fwd('{256, 0, 0, 0}, y, lat);
        do_load;
        run_bwd('{256, 0, 0, 0}, dx, lat);
        check_vec("sgd dx", dx, '{256, 0, 0, 0});
        run_upd(lat);
        run_fwd('{256, 0, 0, 0}, y, lat);
        check_vec("sgd y", y, '{240, 0, 0, 0});

        // update and run_forward requested together: forward goes first
        do_reset;
        @(negedge clk);
        d_forward   = pack('{256, -512, 1024, 3});
        run_forward = 1'b1;
        update      = 1'b1;
        @(posedge clk);
        lat = 0; early = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (valid_update) early = 1;
        end while (!valid_forward && lat < TMO);
        check("tie fwd latency", lat, LAT);
        unpack(q_forward, y);
        check_vec("tie y", y, '{256, -512, 1024, 3});
        @(negedge clk);
        run_forward = 1'b0;
        @(posedge clk); #1;
        check("tie fwd release", int'(valid_forward), 0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!valid_update && lat < TMO);
        check("tie upd latency from fwd idle", lat, LAT + 1);
        check("tie upd early", early, 0);
        @(negedge clk);
        update = 1'b0;
        @(posedge clk); #1;
        check("tie upd release", int'(valid_update), 0);

        // accumulated gradients discarded by zero_grad: W stays identity
        do_reset;
        run_fwd('{256, 512, 0, 0}, y, lat);
        do_load;
        run_bwd('{300, -200, 100, 50}, dx, lat);
        check_vec("zg dx1", dx, '{300, -200, 100, 50});
        run_bwd('{-70, 20, 900, -1}, dx, lat);
        check_vec("zg dx2", dx, '{-70, 20, 900, -1});
        run_zg;
        run_upd(lat);
        for (int j = 0; j < DIM; j++) begin
            for (int k = 0; k < DIM; k++) begin
                x[k] = (k == j) ? ONE : 0;
                e[k] = (k == j) ? ONE : 0;
            end
            run_fwd(x, y, lat);
            check_vec($sformatf("zg wcol%0d", j), y, e);
        end

        // reset in the middle of a forward CALC
        do_reset;
        run_fwd('{1000, 2000, 3000, 4000}, y, lat);
        @(negedge clk);
        d_forward   = pack('{5, 6, 7, 8});
        run_forward = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_forward = 1'b0;
        @(posedge clk); #1;
        check("abort valid_forward", int'(valid_forward), 0);
        check("abort q_forward", int'(q_forward != '0), 0);
        @(negedge clk);
        rst = 1'b0;
        run_fwd('{100, -200, 300, -400}, y, lat);
        check_vec("abort next y", y, '{100, -200, 300, -400});

        // random operation mix against the model
        do_reset;
        model_reset;
        for (int it = 0; it < 40; it++) begin
            int op;
            op = int'($urandom_range(0, 7));
            case (op)
                0, 1, 2: begin
                    for (int k = 0; k < DIM; k++) x[k] = rnd_word();
                    model_forward(x, e);
                    run_fwd(x, y, lat);
                    check($sformatf("rnd%0d fwd latency", it), lat, LAT);
                    check_vec($sformatf("rnd%0d fwd y", it), y, e);
                end
                3: begin
                    xb_m = xf_m;
                    do_load;
                end
                4, 5: begin
                    for (int k = 0; k < DIM; k++) x[k] = rnd_word();
                    model_backward(x, e);
                    run_bwd(x, dx, lat);
                    check($sformatf("rnd%0d bwd latency", it), lat, LAT);
                    check_vec($sformatf("rnd%0d bwd dx", it), dx, e);
                end
                6: begin
                    model_update;
                    run_upd(lat);
                    check($sformatf("rnd%0d upd latency", it), lat, LAT);
                end
                default: begin
                    for (int i = 0; i < DIM; i++)
                        for (int j = 0; j < DIM; j++)
                            dw_m[i][j] = 0;
                    run_zg;
                end
            endcase
        end
        // final read-back of every weight column through the forward path
        model_update;
        run_upd(lat);
        for (int j = 0; j < DIM; j++) begin
            for (int k = 0; k < DIM; k++) x[k] = (k == j) ? ONE : 0;
            model_forward(x, e);
            run_fwd(x, y, lat);
            check_vec($sformatf("rnd final wcol%0d", j), y, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mix_layer_param.md
MIX_LAYER_PARAM -- requirements
Module: mix_layer_param

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  DIM  4  vector length; W is DIM x DIM
  N_LEN  16  signed fixed-point word width
  FRAC  8  fractional bits
  LR_SHIFT  4  learning rate = 2^-LR_SHIFT
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  run_forward  in  1  forward request, level
  d_forward  in  DIM*N_LEN  input vector x, element k at [k*N_LEN +: N_LEN]
  valid_forward  out  1  forward result ready
  q_forward  out  DIM*N_LEN  y = W*x
  load_backward  in  1  copy last forward input into the backward x buffer
  run_backward  in  1  backward request, level
  d_backward  in  DIM*N_LEN  upstream gradient dy
  valid_backward  out  1  backward result ready
  q_backward  out  DIM*N_LEN  dx = W^T*dy
  zero_grad  in  1  clear-gradient request, level
  valid_zero_grad  out  1  clear done
  update  in  1  SGD step request, level
  valid_update  out  1  update done
REQ-003 SHALL use one clock, clk; rst SHALL be synchronous and active-high.

Function
REQ-004 SHALL hold W[i][j] and dW[i][j] (N_LEN signed), x_fwd and x_bwd (DIM words).
REQ-005 SHALL implement forward, backward and update FSMs, each with states IDLE -> CALC -> DONE -> IDLE.
REQ-006 Each FSM SHALL perform one MAC per cycle, so CALC lasts exactly DIM*DIM cycles.
REQ-007 Forward accept: IDLE with run_forward=1 and update FSM IDLE -> capture d_forward into x_fwd, enter CALC.
REQ-008 Forward CALC SHALL compute y[i] = sum_j W[i][j]*x_fwd[j] using a 2*N_LEN+clog2(DIM) accumulator.
REQ-009 Forward output SHALL be each y[i] arithmetic-shifted right by FRAC, then saturated to the signed N_LEN range.
REQ-010 q_forward SHALL be registered; valid_forward SHALL rise on the same edge, DIM*DIM+1 cycles after the accept edge.
REQ-011 DONE SHALL hold valid_forward and q_forward until run_forward=0, then return to IDLE with valid_forward=0 on the next edge.
REQ-012 load_backward=1 in any cycle SHALL copy x_fwd into x_bwd on that edge; it SHALL be ignored while the backward FSM is in CALC.
REQ-013 Backward accept: IDLE with run_backward=1 and update FSM IDLE -> capture dy.
REQ-014 Backward CALC SHALL compute dx[j] = sum_i W[i][j]*dy[i], with the same shift/saturate rules as forward.
REQ-015 Backward CALC SHALL also update dW[i][j] = sat(dW[i][j] + ((dy[i]*x_bwd[j]) >>> FRAC)).
REQ-016 Backward latency and valid_backward hold/release SHALL follow REQ-010/REQ-011.
REQ-017 Forward and backward FSMs SHALL run concurrently; neither SHALL write W.
REQ-018 zero_grad SHALL be accepted only when the backward FSM is IDLE or DONE; it clears all dW in one cycle.
REQ-019 valid_zero_grad SHALL rise the edge after acceptance and stay high until zero_grad=0.
REQ-020 Update accept: IDLE with update=1 and both forward and backward FSMs IDLE.
REQ-021 On a same-cycle request, run_forward/run_backward SHALL win over update; update SHALL wait.
REQ-022 Update CALC SHALL apply W[i][j] = sat(W[i][j] - (dW[i][j] >>> LR_SHIFT)), one element per cycle, row-major.
REQ-023 valid_update SHALL rise DIM*DIM+1 cycles after accept, hold until update=0, and leave dW unchanged.
REQ-024 While the update FSM is not IDLE, run_forward and run_backward SHALL stall in IDLE.

Reset
REQ-025 rst=1 SHALL set all FSMs to IDLE, all valid_* outputs, q_* outputs, dW, x_fwd and x_bwd to 0, and W to identity (1<<FRAC on the diagonal, 0 elsewhere).
REQ-026 rst mid-operation SHALL abort any CALC with no partial writes visible after reset.

Verification (DIM=4, N_LEN=16, FRAC=8, LR_SHIFT=4)
REQ-027 Reset, then forward x=[256,512,-256,128] -> q_forward identical; valid_forward high exactly 17 cycles after accept.
REQ-028 Forward x=[32767,0,0,0] after W[0][0] is raised to 512 via update -> q_forward[0]=32767 (saturated).
REQ-029 Forward x=[256,0,0,0], load_backward, backward dy=[256,0,0,0] -> q_backward=[256,0,0,0], dW[0][0]=256; update -> W[0][0]=240; forward x=[256,0,0,0] -> q_forward[0]=240.
REQ-030 update and run_forward raised in the same cycle -> forward completes first, then update runs; valid_update 17 cycles after its accept.
REQ-031 Two backward passes, zero_grad, then update -> W unchanged (identity); valid_zero_grad one cycle after accept.
REQ-032 rst asserted in cycle 5 of forward CALC -> valid_forward=0, q_forward=0; the next forward on identity W returns its input.
